// File: rtl/wrr_arb_pkg.sv
// -----------------------------------------------------------------------------
// wrr_arb_pkg
// Shared definitions for the weighted round-robin arbiter:
//   - APB register byte addresses
//   - CTRL field positions
//   - FSM state type
//   - TOCNT width and WEIGHT reset value
// -----------------------------------------------------------------------------
package wrr_arb_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_WEIGHT = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_TOCNT  = 8'h0C;

    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_TO_LSB = 8;
    localparam int unsigned CTRL_TO_W   = 8;

    localparam int unsigned TOCNT_W = 16;

    localparam logic [31:0] WEIGHT_RST = 32'h1111_1111;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/wrr_rr_pick.sv
// -----------------------------------------------------------------------------
// wrr_rr_pick
// Combinational rotate-priority picker. Scans the eligible mask starting at
// i_start and wrapping modulo NUM_REQ; the first set bit wins.
// Ports:
//   i_eligible  in   NUM_REQ  candidate mask
//   i_start     in   ID_W     index with highest priority
//   o_winner    out  ID_W     winning index (0 when nothing found)
//   o_found     out  1        at least one eligible bit
// -----------------------------------------------------------------------------
module wrr_rr_pick #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [ID_W-1:0]    i_start,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_found
);

    always_comb begin
        int unsigned     w_pos;
        logic [ID_W-1:0] w_idx;
        o_winner = '0;
        o_found  = 1'b0;
        w_pos    = 0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_pos = 32'(i_start) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_idx = ID_W'(w_pos);
            if (!o_found && i_eligible[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/wrr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// wrr_arb_ctrl
// APB-programmable weighted round-robin arbiter with a grant watchdog.
// A grant covers one transaction, closed by the grantee's done pulse. A
// requester may take up to weight[i] back-to-back transactions (credit)
// before the search pointer moves on.
// Ports:
//   Pclk_i, PResetn_i            clock, async active-low reset
//   PSel_i/PEnable_i/PWrite_i    APB control
//   PAddr_i, PWData_i            APB address / write data
//   PRData_o, PReady_o           APB read data (registered) / always ready
//   req_i                        level requests
//   done_i                       per-requester end-of-transaction pulse
//   gnt_o, gnt_valid_o, gnt_id_o registered one-hot grant, valid, index
//   timeout_o                    pulse in the cycle a grant is revoked
// -----------------------------------------------------------------------------
module wrr_arb_ctrl
    import wrr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               Pclk_i,
    input  logic               PResetn_i,
    input  logic               PSel_i,
    input  logic               PEnable_i,
    input  logic               PWrite_i,
    input  logic [7:0]         PAddr_i,
    input  logic [31:0]        PWData_i,
    output logic [31:0]        PRData_o,
    output logic               PReady_o,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               timeout_o
);

    // APB registers
    logic                r_enable;
    logic [CTRL_TO_W-1:0] r_timeout;
    logic [31:0]         r_weight;
    logic [TOCNT_W-1:0]  r_tocnt;
    logic [31:0]         r_prdata;

    // Arbiter state
    state_t              r_state;
    logic [ID_W-1:0]     r_last_id;
    logic [ID_W-1:0]     r_gnt_id;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [WEIGHT_W-1:0] r_credit;
    logic [7:0]          r_timer;

    logic                w_apb_wr;
    logic                w_apb_rd_setup;
    logic [NUM_REQ-1:0]  w_eligible;
    logic [7:0]          w_popcnt;
    logic [ID_W-1:0]     w_start;
    logic [ID_W-1:0]     w_pick_id;
    logic                w_pick_found;
    logic [WEIGHT_W-1:0] w_pick_weight;
    logic                w_keep;
    logic [ID_W-1:0]     w_win_id;
    logic                w_start_grant;
    logic                w_done;
    logic                w_timeout;
    logic [31:0]         w_status;
    logic [31:0]         w_rdata;

    assign w_apb_wr       = PSel_i & PEnable_i & PWrite_i;
    assign w_apb_rd_setup = PSel_i & ~PEnable_i & ~PWrite_i;

    // A zero weight masks the requester entirely.
    always_comb begin
        w_eligible = '0;
        w_popcnt   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_i[i] & (r_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
            w_popcnt      = w_popcnt + 8'(req_i[i]);
        end
    end

    assign w_start = (r_last_id == ID_W'(NUM_REQ - 1)) ? '0 : r_last_id + 1'b1;

    wrr_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_start    (w_start),
        .o_winner   (w_pick_id),
        .o_found    (w_pick_found)
    );

    assign w_pick_weight = r_weight[32'(w_pick_id)*WEIGHT_W +: WEIGHT_W];

    // Remaining credit lets the previous winner go again without a search.
    assign w_keep        = (r_credit != '0) && w_eligible[r_last_id];
    assign w_win_id      = w_keep ? r_last_id : w_pick_id;
    assign w_start_grant = (r_state == IDLE) && r_enable && (w_keep || w_pick_found);

    // Done beats a coincident timeout; done bits of other requesters are ignored.
    assign w_done    = (r_state == GRANT) && done_i[r_gnt_id];
    assign w_timeout = (r_state == GRANT) && !w_done && (r_timeout != '0) &&
                       (r_timer == r_timeout - 8'd1);

    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            r_state   <= IDLE;
            r_last_id <= ID_W'(NUM_REQ - 1);
            r_gnt_id  <= '0;
            r_gnt     <= '0;
            r_credit  <= '0;
            r_timer   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_grant) begin
                        r_state   <= GRANT;
                        r_last_id <= w_win_id;
                        r_gnt_id  <= w_win_id;
                        r_gnt     <= NUM_REQ'(1) << w_win_id;
                        r_timer   <= '0;
                        if (!w_keep) begin
                            r_credit <= w_pick_weight;
                        end
                    end
                end
                GRANT: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        if (r_credit != '0) begin
                            r_credit <= r_credit - 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state  <= IDLE;
                        r_gnt    <= '0;
                        r_credit <= '0;
                    end else if (!r_enable) begin
                        // last_id and credit survive a disable
                        r_state <= IDLE;
                        r_gnt   <= '0;
                    end else if (r_timer != 8'hFF) begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            r_enable  <= 1'b0;
            r_timeout <= '0;
            r_weight  <= WEIGHT_RST;
        end else if (w_apb_wr) begin
            case (PAddr_i)
                ADDR_CTRL: begin
                    r_enable  <= PWData_i[CTRL_EN_BIT];
                    r_timeout <= PWData_i[CTRL_TO_LSB +: CTRL_TO_W];
                end
                ADDR_WEIGHT: r_weight <= PWData_i;
                default: ;
            endcase
        end
    end

    // Software clear takes precedence over a coincident timeout.
    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            r_tocnt <= '0;
        end else if (w_apb_wr && (PAddr_i == ADDR_TOCNT)) begin
            r_tocnt <= '0;
        end else if (w_timeout && (r_tocnt != '1)) begin
            r_tocnt <= r_tocnt + 1'b1;
        end
    end

    always_comb begin
        w_status                  = '0;
        w_status[0]               = (r_state == GRANT);
        w_status[4 +: ID_W]       = r_gnt_id;
        w_status[15:8]            = w_popcnt;
        w_status[16 +: WEIGHT_W]  = r_credit;
    end

    always_comb begin
        w_rdata = '0;
        case (PAddr_i)
            ADDR_CTRL:   w_rdata = {16'h0, r_timeout, 7'h0, r_enable};
            ADDR_WEIGHT: w_rdata = r_weight;
            ADDR_STATUS: w_rdata = w_status;
            ADDR_TOCNT:  w_rdata = 32'(r_tocnt);
            default:     w_rdata = '0;
        endcase
    end

    // Read data is captured in the setup phase so it is stable in the access phase.
    always_ff @(posedge Pclk_i or negedge PResetn_i) begin
        if (!PResetn_i) begin
            r_prdata <= '0;
        end else if (w_apb_rd_setup) begin
            r_prdata <= w_rdata;
        end
    end

    assign PRData_o    = r_prdata;
    assign PReady_o    = 1'b1;
    assign gnt_o       = r_gnt;
    assign gnt_valid_o = |r_gnt;
    assign gnt_id_o    = r_gnt_id;
    assign timeout_o   = w_timeout;

endmodule

// File: tb/tb_wrr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wrr_arb_ctrl
// Scoreboard bench for wrr_arb_ctrl. A behavioural model steps once per clock
// and pushes expected grants/timeouts into queues; a negedge monitor pops and
// compares them against what the DUT presents.
// -----------------------------------------------------------------------------
module tb_wrr_arb_ctrl;

    localparam int NUM_REQ = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic [7:0]  req = '0, done = '0;
    logic [7:0]  gnt;
    logic        gnt_valid;
    logic [2:0]  gnt_id;
    logic        timeout;

    wrr_arb_ctrl dut (
        .Pclk_i      (clk),
        .PResetn_i   (rst_n),
        .PSel_i      (psel),
        .PEnable_i   (penable),
        .PWrite_i    (pwrite),
        .PAddr_i     (paddr),
        .PWData_i    (pwdata),
        .PRData_o    (prdata),
        .PReady_o    (pready),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    bit          m_en;
    int          m_to;
    logic [31:0] m_weight;
    int          m_tocnt;
    bit          m_busy;
    int          m_id, m_last, m_credit, m_age, m_gnt_id;
    // Model view of the DUT during the current cycle
    bit          s_busy;
    int          s_id, s_gnt_id;

    typedef struct { int id; int cyc; } gexp_t;
    gexp_t gq[$];
    int    tq[$];
    int    glog[$];
    int    to_gap[$];
    int    rise_cyc = 0;

    // Stimulus policy
    logic [7:0]  g_req   = '0;
    int          g_delay = -1;
    bit          g_noise = 1'b0;
    logic [31:0] exp_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int weight_of(input int i);
        return int'((m_weight >> (4 * i)) & 32'hF);
    endfunction

    function automatic bit elig(input int i);
        return req[i] && (weight_of(i) != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return {16'h0, 8'(m_to), 7'h0, m_en};
            8'h04:   return m_weight;
            8'h08:   return (32'(m_credit) << 16) | (32'($countones(req)) << 8) |
                            (32'(m_gnt_id) << 4) | 32'(m_busy);
            8'h0C:   return 32'(m_tocnt);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_to = 0; m_weight = 32'h1111_1111; m_tocnt = 0;
        m_busy = 0; m_id = 0; m_last = NUM_REQ - 1; m_credit = 0; m_age = 0; m_gnt_id = 0;
        s_busy = 0; s_id = 0; s_gnt_id = 0;
        gq.delete();
        tq.delete();
    endtask

    // One clock of the arbitration rules, using the inputs present this cycle.
    task automatic model_step();
        int win;
        win = -1;
        s_busy = m_busy; s_id = m_id; s_gnt_id = m_gnt_id;
        if (!m_busy) begin
            if (m_en) begin
                if (m_credit != 0 && elig(m_last)) begin
                    win = m_last;
                end else begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        if (win < 0 && elig((m_last + k) % NUM_REQ)) begin
                            win = (m_last + k) % NUM_REQ;
                            m_credit = weight_of(win);
                        end
                    end
                end
            end
            if (win >= 0) begin
                m_busy = 1; m_id = win; m_last = win; m_gnt_id = win; m_age = 0;
                gq.push_back('{win, cyc});
            end
        end else if (done[m_id]) begin
            if (m_credit > 0) m_credit--;
            m_busy = 0;
        end else if (m_to != 0 && m_age == m_to - 1) begin
            tq.push_back(m_id);
            m_credit = 0;
            if (m_tocnt < 65535) m_tocnt++;
            m_busy = 0;
        end else if (!m_en) begin
            m_busy = 0;
        end else if (m_age < 255) begin
            m_age++;
        end
        if (psel && penable && pwrite) begin
            case (paddr)
                8'h00: begin m_en = pwdata[0]; m_to = int'(pwdata[15:8]); end
                8'h04: m_weight = pwdata;
                8'h0C: m_tocnt = 0;
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        req  = g_req;
        done = '0;
        if (g_delay >= 0 && m_busy && m_age == g_delay) done[m_id] = 1'b1;
        if (g_noise) done = done | (8'($urandom) & ~(m_busy ? (8'd1 << m_id) : 8'd0));
        if (psel && !penable && !pwrite) exp_rdata = model_read(paddr);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        cycle();
        penable = 1;
        cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [7:0] a, input string name, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        cycle();
        penable = 1;
        d = prdata;
        check(name, prdata, exp_rdata);
        cycle();
        psel = 0; penable = 0;
    endtask

    task automatic apply_reset();
        model_reset();
        psel = 0; penable = 0; pwrite = 0; req = '0; done = '0;
        g_req = '0; g_delay = -1; g_noise = 0;
        rst_n = 0;
        #2;
        check("rst_gnt_o", 32'(gnt), 32'h0);
        check("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("pready", 32'(pready), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        glog.delete();
        to_gap.delete();
    endtask

    // Monitor: compares DUT outputs against the model's view of this cycle.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        gexp_t g;
        bit    exp_to;
        check("gnt_o", 32'(gnt), s_busy ? (32'd1 << s_id) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(s_busy));
        check("gnt_id", 32'(gnt_id), 32'(s_gnt_id));
        if (tq.size() > 0 || timeout) begin
            exp_to = (tq.size() > 0);
            check("timeout_o", 32'(timeout), 32'(exp_to));
            if (tq.size() > 0) void'(tq.pop_front());
            if (timeout) to_gap.push_back(cyc - rise_cyc);
        end
        if (gnt_valid && !prev_valid) begin
            rise_cyc = cyc;
            glog.push_back(int'(gnt_id));
            if (gq.size() == 0) begin
                check("grant_unexpected", 32'(gnt_id), 32'hFFFF_FFFF);
            end else begin
                g = gq.pop_front();
                check("grant_order", 32'(gnt_id), 32'(g.id));
                check("grant_latency", 32'(cyc - 1), 32'(g.cyc));
            end
        end else if (gq.size() > 0 && gq[0].cyc < cyc - 1) begin
            g = gq.pop_front();
            check("grant_missing", 32'(gnt_valid), 32'h1);
        end
        prev_valid = gnt_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          r;
        int          exp_order[$];

        model_reset();
        apply_reset();
        apb_read(8'h00, "ctrl_reset", d);
        apb_read(8'h04, "weight_reset", d);
        apb_read(8'h08, "status_reset", d);
        apb_read(8'h0C, "tocnt_reset", d);

        // Default weights, two requesters alternate.
        apb_write(8'h00, 32'h1);
        g_req = 8'h05; g_delay = 2;
        for (int i = 0; i < 300 && glog.size() < 4; i++) cycle();
        exp_order = '{0, 2, 0, 2};
        check("order_0202_len", 32'(glog.size() >= 4), 32'h1);
        for (int i = 0; i < 4 && i < glog.size(); i++) check("order_0202", 32'(glog[i]), 32'(exp_order[i]));
        g_req = '0; run(10);

        // Weight 1 for requester 0, 3 for requester 1.
        apply_reset();
        apb_write(8'h04, 32'h0000_0031);
        apb_write(8'h00, 32'h1);
        g_req = 8'h03; g_delay = 1;
        for (int i = 0; i < 300 && glog.size() < 8; i++) cycle();
        exp_order = '{0, 1, 1, 1, 0, 1, 1, 1};
        check("order_w31_len", 32'(glog.size() >= 8), 32'h1);
        for (int i = 0; i < 8 && i < glog.size(); i++) check("order_w31", 32'(glog[i]), 32'(exp_order[i]));
        g_req = '0; run(10);

        // Watchdog of 4 cycles, requester never finishes.
        apply_reset();
        apb_write(8'h00, 32'h0401);
        g_req = 8'h02; g_delay = -1;
        for (int i = 0; i < 60 && to_gap.size() == 0; i++) cycle();
        check("timeout_seen", 32'(to_gap.size()), 32'h1);
        if (to_gap.size() > 0) check("timeout_gap", 32'(to_gap[0]), 32'd3);
        apb_read(8'h0C, "tocnt_after_to", d);
        check("tocnt_one", d, 32'h1);
        run(12);
        check("regrant_after_to", 32'(glog.size() >= 2), 32'h1);
        g_req = '0; run(10);

        // Done coincides with the watchdog expiry; stray done bits of others.
        apply_reset();
        apb_write(8'h00, 32'h0401);
        g_req = 8'h02; g_delay = 3; g_noise = 1;
        run(40);
        apb_read(8'h0C, "tocnt_done_wins", d);
        check("tocnt_zero", d, 32'h0);
        g_req = '0; g_noise = 0; run(10);

        // Disable mid-grant, then re-enable with two requesters.
        apply_reset();
        apb_write(8'h00, 32'h1);
        g_req = 8'h01; g_delay = -1;
        run(4);
        apb_write(8'h00, 32'h0);
        run(4);
        g_req = 8'h81; g_delay = 1;
        apb_write(8'h00, 32'h1);
        run(30);
        g_req = '0; run(10);

        // Masked requester, then asynchronous reset during a grant.
        apply_reset();
        apb_write(8'h04, 32'h1111_1011);
        apb_write(8'h00, 32'h1);
        g_req = 8'h04;
        run(20);
        check("masked_no_grant", 32'(glog.size()), 32'h0);
        apb_read(8'h08, "status_masked", d);
        check("status_busy0", 32'(d[0]), 32'h0);
        check("status_pop1", 32'(d[15:8]), 32'h1);
        g_req = 8'h01; g_delay = -1;
        for (int i = 0; i < 20 && !m_busy; i++) cycle();
        run(2);
        check("busy_before_reset", 32'(gnt_valid), 32'h1);
        apply_reset();

        // Randomised traffic and register activity.
        apb_write(8'h04, $urandom);
        apb_write(8'h00, {16'h0, 8'($urandom_range(0, 10)), 8'h1});
        for (int i = 0; i < 1500; i++) begin
            if (i % 20 == 0) begin
                g_req   = 8'($urandom);
                g_delay = int'($urandom_range(0, 9)) - 1;
                g_noise = ($urandom_range(0, 1) == 1);
            end
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                case ($urandom_range(0, 4))
                    0: apb_read(8'h00, "rnd_ctrl", d);
                    1: apb_read(8'h04, "rnd_weight", d);
                    2: apb_read(8'h08, "rnd_status", d);
                    3: apb_read(8'h0C, "rnd_tocnt", d);
                    default: apb_read(8'h10, "rnd_unmapped", d);
                endcase
            end else if (r < 10) begin
                apb_write(8'h04, $urandom);
            end else if (r < 12) begin
                apb_write(8'h00, {16'h0, 8'($urandom_range(0, 12)),
                                  7'h0, 1'($urandom_range(0, 4) != 0)});
            end else if (r < 13) begin
                apb_write(8'h0C, 32'h0);
            end else if (r < 14) begin
                apb_write(8'h14, $urandom);
            end else begin
                cycle();
            end
        end
        apb_read(8'h00, "final_ctrl", d);
        apb_read(8'h04, "final_weight", d);
        apb_read(8'h0C, "final_tocnt", d);
        g_req = '0; g_delay = 0; g_noise = 0;
        run(20);
        check("grant_queue_empty", 32'(gq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
